ram_1port_arbiter: RTL and testbench

//  Shares one single-port RAM (1-cycle registered read, Rd_En->Rd_DV pulse) between
//  two requesters A and B. Arbitrates, registers one command per cycle onto the RAM

---
 rtl/ram_1port_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_1port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1port_arbiter.sv
// Two-requester arbiter in front of one single-port RAM with a 1-cycle registered read.
// Registers the winning command onto the RAM port and routes read data back to the requester that issued the read.
module ram_1port_arbiter #(
  parameter  int WIDTH      = 16,
  parameter  int DEPTH      = 256,
  parameter  int PRIO_MODE  = 0,
  parameter  int STARVE_MAX = 4,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,

  input  logic              i_A_Req,
  input  logic              i_A_Wr,
  input  logic [ADDR_W-1:0] i_A_Addr,
  input  logic [WIDTH-1:0]  i_A_Wr_Data,
  output logic              o_A_Gnt,
  output logic              o_A_Rd_DV,
  output logic [WIDTH-1:0]  o_A_Rd_Data,

  input  logic              i_B_Req,
  input  logic              i_B_Wr,
  input  logic [ADDR_W-1:0] i_B_Addr,
  input  logic [WIDTH-1:0]  i_B_Wr_Data,
  output logic              o_B_Gnt,
  output logic              o_B_Rd_DV,
  output logic [WIDTH-1:0]  o_B_Rd_Data,

  output logic [ADDR_W-1:0] o_Ram_Addr,
  output logic              o_Ram_Wr_DV,
  output logic [WIDTH-1:0]  o_Ram_Wr_Data,
  output logic              o_Ram_Rd_En,
  input  logic              i_Ram_Rd_DV,
  input  logic [WIDTH-1:0]  i_Ram_Rd_Data
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // One tag per RAM slot in flight: was it a read, and who asked for it.
  typedef struct packed {
    logic   rd_valid;
    owner_e owner;
  } tag_t;

  owner_e              last_owner;
  logic [STARVE_W-1:0] starve_cnt;
  tag_t                stage1;
  tag_t                stage2;

  logic                req_a;
  logic                req_b;
  logic                gnt_a;
  logic                gnt_b;
  logic                any_gnt;
  owner_e              win_owner;
  logic                win_wr;
  logic [ADDR_W-1:0]   win_addr;
  logic [WIDTH-1:0]    win_wr_data;

  // Grants are forced low while reset is asserted.
  assign req_a = i_A_Req & i_Rst_L;
  assign req_b = i_B_Req & i_Rst_L;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && req_b) begin
      if (PRIO_MODE == 0) begin
        if (last_owner == OWNER_A) gnt_b = 1'b1;
        else                       gnt_a = 1'b1;
      end else begin
        if (starve_cnt == STARVE_LIM) gnt_b = 1'b1;
        else                          gnt_a = 1'b1;
      end
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

  always_comb begin
    any_gnt     = gnt_a | gnt_b;
    win_owner   = gnt_b ? OWNER_B : OWNER_A;
    win_wr      = gnt_b ? i_B_Wr      : i_A_Wr;
    win_addr    = gnt_b ? i_B_Addr    : i_A_Addr;
    win_wr_data = gnt_b ? i_B_Wr_Data : i_A_Wr_Data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Ram_Addr    <= '0;
      o_Ram_Wr_DV   <= 1'b0;
      o_Ram_Wr_Data <= '0;
      o_Ram_Rd_En   <= 1'b0;
      last_owner    <= OWNER_B;
      stage1        <= '0;
      stage2        <= '0;
    end else begin
      o_Ram_Wr_DV <= any_gnt & win_wr;
      o_Ram_Rd_En <= any_gnt & ~win_wr;
      // Address and data hold through idle cycles.
      if (any_gnt) begin
        o_Ram_Addr    <= win_addr;
        o_Ram_Wr_Data <= win_wr_data;
        last_owner    <= win_owner;
      end
      stage1 <= '{rd_valid: any_gnt & ~win_wr, owner: win_owner};
      stage2 <= stage1;
    end
  end

  // B starvation guard; only meaningful in fixed-priority mode.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      starve_cnt <= '0;
    end else if (PRIO_MODE != 0) begin
      if (gnt_b) begin
        starve_cnt <= '0;
      end else if (req_b && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign o_A_Gnt     = gnt_a;
  assign o_B_Gnt     = gnt_b;
  assign o_A_Rd_DV   = i_Ram_Rd_DV & stage2.rd_valid & (stage2.owner == OWNER_A);
  assign o_B_Rd_DV   = i_Ram_Rd_DV & stage2.rd_valid & (stage2.owner == OWNER_B);
  assign o_A_Rd_Data = i_Ram_Rd_Data;
  assign o_B_Rd_Data = i_Ram_Rd_Data;

endmodule

// File: tb/tb_ram_1port_arbiter.sv
// Bench for ram_1port_arbiter: a round-robin instance behind a behavioural RAM, checked by
// a read scoreboard, plus a fixed-priority instance checked for its grant pattern.
module tb_ram_1port_arbiter;

  typedef struct {
    bit          nop;
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } op_t;

  typedef struct {
    logic        owner;
    logic [15:0] data;
    int          cyc;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // round-robin DUT signals
  logic        a_req, a_wr, b_req, b_wr;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rd_dv, b_rd_dv;
  logic [15:0] a_rd_data, b_rd_data;
  logic [7:0]  ram_addr;
  logic        ram_wr_dv, ram_rd_en, ram_rd_dv;
  logic [15:0] ram_wr_data, ram_rd_data;

  ram_1port_arbiter #(.WIDTH(16), .DEPTH(256), .PRIO_MODE(0), .STARVE_MAX(4)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_A_Req(a_req), .i_A_Wr(a_wr), .i_A_Addr(a_addr), .i_A_Wr_Data(a_wdata),
    .o_A_Gnt(a_gnt), .o_A_Rd_DV(a_rd_dv), .o_A_Rd_Data(a_rd_data),
    .i_B_Req(b_req), .i_B_Wr(b_wr), .i_B_Addr(b_addr), .i_B_Wr_Data(b_wdata),
    .o_B_Gnt(b_gnt), .o_B_Rd_DV(b_rd_dv), .o_B_Rd_Data(b_rd_data),
    .o_Ram_Addr(ram_addr), .o_Ram_Wr_DV(ram_wr_dv), .o_Ram_Wr_Data(ram_wr_data),
    .o_Ram_Rd_En(ram_rd_en), .i_Ram_Rd_DV(ram_rd_dv), .i_Ram_Rd_Data(ram_rd_data)
  );

  // fixed-priority DUT signals
  logic        p_a_req = 1'b0, p_b_req = 1'b0;
  logic        p_zero = 1'b0;
  logic [7:0]  p_addr = 8'h00;
  logic [15:0] p_data = 16'h0000;
  logic        p_a_gnt, p_b_gnt, p_a_dv, p_b_dv, p_wr_dv, p_rd_en;
  logic [15:0] p_a_rdata, p_b_rdata, p_wr_data;
  logic [7:0]  p_ram_addr;

  ram_1port_arbiter #(.WIDTH(16), .DEPTH(256), .PRIO_MODE(1), .STARVE_MAX(4)) dut_prio (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_A_Req(p_a_req), .i_A_Wr(p_zero), .i_A_Addr(p_addr), .i_A_Wr_Data(p_data),
    .o_A_Gnt(p_a_gnt), .o_A_Rd_DV(p_a_dv), .o_A_Rd_Data(p_a_rdata),
    .i_B_Req(p_b_req), .i_B_Wr(p_zero), .i_B_Addr(p_addr), .i_B_Wr_Data(p_data),
    .o_B_Gnt(p_b_gnt), .o_B_Rd_DV(p_b_dv), .o_B_Rd_Data(p_b_rdata),
    .o_Ram_Addr(p_ram_addr), .o_Ram_Wr_DV(p_wr_dv), .o_Ram_Wr_Data(p_wr_data),
    .o_Ram_Rd_En(p_rd_en), .i_Ram_Rd_DV(p_zero), .i_Ram_Rd_Data(p_data)
  );

  // Single-port RAM with 1-cycle registered read; contents survive arbiter reset.
  logic [15:0] mem [256] = '{default: 16'h0000};
  logic        ram_dv_q = 1'b0;
  logic [15:0] ram_data_q = 16'h0000;
  logic        stray = 1'b0;
  always @(posedge clk) begin
    if (ram_wr_dv) mem[ram_addr] <= ram_wr_data;
    ram_dv_q <= ram_rd_en;
    if (ram_rd_en) ram_data_q <= mem[ram_addr];
  end
  assign ram_rd_dv   = ram_dv_q | stray;
  assign ram_rd_data = ram_data_q;

  // Reference model: memory contents in grant order, last grant owner, last address.
  logic [15:0] ref_mem [256];
  logic        model_last;
  logic [7:0]  last_addr;
  rd_exp_t     exp_q[$];
  op_t         qa[$];
  op_t         qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input bit nop, input logic wr, input logic [7:0] addr,
                             input logic [15:0] data);
    op_t o;
    o.nop = nop; o.wr = wr; o.addr = addr; o.data = data;
    return o;
  endfunction

  function automatic logic [1:0] model_arb(input logic ra, input logic rb);
    if (!rst_n) return 2'b00;
    if (ra && rb) return model_last ? 2'b10 : 2'b01;
    return {ra, rb};
  endfunction

  task automatic apply(input logic owner, input logic wr, input logic [7:0] addr,
                       input logic [15:0] data);
    rd_exp_t e;
    model_last = owner;
    last_addr  = addr;
    if (wr) begin
      ref_mem[addr] = data;
    end else begin
      e.owner = owner; e.data = ref_mem[addr]; e.cyc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_reset();
    model_last = 1'b1;
    last_addr  = 8'h00;
    exp_q.delete();
  endtask

  // Present queued ops (held until granted), check grants, feed the model.
  task automatic run_ops(input int max_cycles, input int gap_pct);
    int n = 0;
    bit a_hold = 0, b_hold = 0;
    logic [1:0] eg;
    while ((qa.size() > 0 || qb.size() > 0) && n < max_cycles) begin
      a_req = 1'b0;
      b_req = 1'b0;
      if (qa.size() > 0) begin
        if (qa[0].nop) void'(qa.pop_front());
        else if (a_hold || $urandom_range(99) >= gap_pct) begin
          a_req = 1'b1; a_hold = 1;
          a_wr = qa[0].wr; a_addr = qa[0].addr; a_wdata = qa[0].data;
        end
      end
      if (qb.size() > 0) begin
        if (qb[0].nop) void'(qb.pop_front());
        else if (b_hold || $urandom_range(99) >= gap_pct) begin
          b_req = 1'b1; b_hold = 1;
          b_wr = qb[0].wr; b_addr = qb[0].addr; b_wdata = qb[0].data;
        end
      end
      #1;
      eg = model_arb(a_req, b_req);
      check("gnt_a", a_gnt, eg[1]);
      check("gnt_b", b_gnt, eg[0]);
      if (eg[1]) begin
        apply(1'b0, a_wr, a_addr, a_wdata);
        void'(qa.pop_front()); a_hold = 0;
      end
      if (eg[0]) begin
        apply(1'b1, b_wr, b_addr, b_wdata);
        void'(qb.pop_front()); b_hold = 0;
      end
      @(negedge clk);
      n++;
    end
    check("run_timeout_left", qa.size() + qb.size(), 0);
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    check("pending_reads", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every read-valid pulse must match the oldest expected read.
  always @(negedge clk) begin
    rd_exp_t e;
    if (a_rd_dv || b_rd_dv) begin
      check("rd_dv_onehot", {31'd0, a_rd_dv & b_rd_dv}, 0);
      if (exp_q.size() == 0) begin
        check("rd_dv_unexpected", {30'd0, a_rd_dv, b_rd_dv}, 0);
      end else begin
        e = exp_q.pop_front();
        check("rd_owner", {31'd0, b_rd_dv}, {31'd0, e.owner});
        check("rd_data", b_rd_dv ? b_rd_data : a_rd_data, e.data);
        check("rd_latency", cyc - e.cyc, 2);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    rst_n = 1'b0;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h00; a_wdata = 16'h0000;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 8'h00; b_wdata = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt_a", a_gnt, 0);
    check("rst_gnt_b", b_gnt, 0);
    check("rst_wr_dv", ram_wr_dv, 0);
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wr_data", ram_wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;

    // 1: A writes 0xBEEF @0x10 then reads it back.
    qa.push_back(mk(0, 1'b1, 8'h10, 16'hBEEF));
    qa.push_back(mk(0, 1'b0, 8'h10, 16'h0000));
    run_ops(20, 0);
    drain();

    // 2: both sides read every cycle; round-robin alternates.
    for (int i = 0; i < 6; i++) begin
      qa.push_back(mk(0, 1'b0, 8'(8'h10 + i), 16'h0));
      qb.push_back(mk(0, 1'b0, 8'(8'h40 + i), 16'h0));
    end
    run_ops(40, 0);
    drain();

    // 4: B write @5 then A read @5 one cycle later sees the new data.
    qb.push_back(mk(0, 1'b1, 8'h05, 16'h1234));
    qa.push_back(mk(1, 1'b0, 8'h00, 16'h0000));
    qa.push_back(mk(0, 1'b0, 8'h05, 16'h0000));
    run_ops(20, 0);
    drain();

    // 6: ten idle cycles, strobes low and address held.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_wr_dv", ram_wr_dv, 0);
      check("idle_rd_en", ram_rd_en, 0);
      check("idle_addr", ram_addr, last_addr);
    end

    // Stray read-valid with no read in flight is ignored.
    @(negedge clk);
    #2 stray = 1'b1;
    #1;
    check("stray_a_dv", a_rd_dv, 0);
    check("stray_b_dv", b_rd_dv, 0);
    stray = 1'b0;

    // Randomized traffic on a small address window to force collisions.
    for (int i = 0; i < 150; i++) begin
      qa.push_back(mk(0, 1'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom)));
      qb.push_back(mk(0, 1'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom)));
    end
    @(negedge clk);
    run_ops(3000, 30);
    drain();

    // 5: reset one cycle after an A read grant drops the read.
    @(negedge clk);
    qa.push_back(mk(0, 1'b0, 8'h10, 16'h0000));
    run_ops(10, 0);
    check("t5_rd_en_before", ram_rd_en, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    a_req = 1'b1; a_wr = 1'b0;
    b_req = 1'b1; b_wr = 1'b0;
    #1;
    check("t5_rd_en", ram_rd_en, 0);
    check("t5_wr_dv", ram_wr_dv, 0);
    check("t5_addr", ram_addr, 0);
    check("t5_gnt_a", a_gnt, 0);
    check("t5_gnt_b", b_gnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    qa.push_back(mk(0, 1'b0, 8'h10, 16'h0000));
    qb.push_back(mk(0, 1'b0, 8'h05, 16'h0000));
    run_ops(10, 0);
    drain();

    // 3: fixed priority with starvation guard, both requesting continuously.
    @(negedge clk);
    p_a_req = 1'b1;
    p_b_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("prio_gnt_a", p_a_gnt, (i % 5) != 4);
      check("prio_gnt_b", p_b_gnt, (i % 5) == 4);
      @(negedge clk);
    end
    p_a_req = 1'b0;
    #1;
    check("prio_b_alone", p_b_gnt, 1);
    check("prio_a_idle", p_a_gnt, 0);
    @(negedge clk);
    p_a_req = 1'b0;
    p_b_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
